gpio_debounce: RTL
==================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of input pins conditioned.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: depth of the synchroniser chain per pin.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, legal range 1..65535: consecutive stable cycles required to accept a new level.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port pin_raw_i, input, WIDTH bits: asynchronous, bouncing board pins.
REQ-007 The block SHALL have port pin_o, output, WIDTH bits: debounced pin levels; this port drives the GPIO peripheral pin_input bus directly.
REQ-008 The block SHALL have port rise_o, output, WIDTH bits: one-cycle pulse per pin on an accepted 0->1 transition.
REQ-009 The block SHALL have port fall_o, output, WIDTH bits: one-cycle pulse per pin on an accepted 1->0 transition.

Function
REQ-010 Each pin SHALL pass through a SYNC_STAGES-deep flop chain; sync_out denotes the last stage.
REQ-011 Each pin SHALL have an independent counter, width clog2(DEBOUNCE_CYCLES) (minimum 1 bit), with no interaction between pins.
REQ-012 At each edge, if sync_out equals pin_o, the counter SHALL load 0, pin_o SHALL hold, and no pulse SHALL be produced.
REQ-013 At each edge, if sync_out differs from pin_o and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 At each edge, if sync_out differs from pin_o and the counter equals DEBOUNCE_CYCLES-1, pin_o SHALL load sync_out, the counter SHALL load 0, and rise_o or fall_o SHALL assert.
REQ-015 The pulse in REQ-014 SHALL be registered and SHALL be high exactly during the cycle following that edge, coincident with the new pin_o value.
REQ-016 rise_o and fall_o SHALL never be high simultaneously for the same pin, and a pulse SHALL never exceed one cycle.
REQ-017 Latency SHALL be as follows: a raw level that changes before edge 1 and then stays stable SHALL appear on pin_o after edge SYNC_STAGES+DEBOUNCE_CYCLES, with no earlier change.
REQ-018 A disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sync_out cycles SHALL NOT change pin_o, and the counter SHALL restart from 0 on the next disagreement.
REQ-019 With DEBOUNCE_CYCLES=1, the first disagreeing edge SHALL update pin_o, giving a latency of SYNC_STAGES+1.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 Simultaneous transitions on multiple pins SHALL each be debounced independently, and pulses on different pins MAY coincide.
REQ-022 pin_o, rise_o and fall_o SHALL be driven only from flops, with no combinational path from pin_raw_i.

Reset
REQ-023 While rst_ni is low, all synchroniser flops, counters, pin_o, rise_o and fall_o SHALL be 0, taking effect immediately and without waiting for clk_i.
REQ-024 Deassertion of rst_ni SHALL be synchronous to clk_i.
REQ-025 After reset, a pin held high SHALL produce one rise_o pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges, per REQ-017.
REQ-026 Reset asserted mid-count SHALL discard the count, and no pulse SHALL be emitted for the interrupted transition.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WIDTH=8 unless stated)
REQ-027 Reset release scenario: pin_raw_i=0xFF, rst_ni released -> pin_o=0x00 through edge 5; pin_o=0xFF and rise_o=0xFF in the cycle after edge 6; rise_o=0x00 thereafter.
REQ-028 Glitch rejection scenario: with pin_o=0x00, bit0 raw high for 3 cycles then low -> pin_o stays 0x00 and no pulses; then bit0 high for 4+ cycles -> pin_o=0x01 after edge 6 from the change, with a single rise_o[0] pulse.
REQ-029 Mixed directions scenario: pin_o=0x20, raw changes to 0x08 in one cycle -> after 6 edges pin_o=0x08, rise_o=0x08 and fall_o=0x20 in the same cycle.
REQ-030 Reset mid-count scenario: bit2 disagreeing with counter at 2, rst_ni pulsed low between edges -> pin_o=0x00 at once with no pulse, and the count restarts from 0 after release.
REQ-031 Minimum debounce scenario: DEBOUNCE_CYCLES=1, raw bit7 0->1 -> pin_o[7]=1 after edge 3 with a single rise_o[7] pulse.
REQ-032 Chatter scenario: raw bit4 toggling every 2 cycles for 100 cycles -> pin_o[4] never changes and rise_o/fall_o stay 0.

Source files
------------

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin synchroniser + debounce filter for asynchronous,
// bouncing board inputs. Each pin is conditioned by an independent lane
// instance. A pin only takes a new level after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock edges. Registered
// one-cycle rise/fall pulses accompany every accepted change.
//
// rst_ni asserts asynchronously and clears every flop. Its deassertion is
// expected to arrive synchronous to clk_i. No internal reset synchroniser is
// added, so the post-reset latency stays exactly SYNC_STAGES+DEBOUNCE_CYCLES.

// ---------------------------------------------------------------------------
// One conditioned pin: synchroniser chain, stability counter, output flops.
// ---------------------------------------------------------------------------
module gpio_debounce_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit so
    // the DEBOUNCE_CYCLES=1 case still elaborates cleanly.
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: raw enters at bit 0, the settled sample leaves at the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce decision: count consecutive disagreeing edges and accept the
    // new level on the edge where the count has already reached its last value.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_out != level_q) begin
            if (cnt_q == CNT_LAST) begin
                // Accept: counter goes back to 0, pulse goes out with the new level.
                level_d = sync_out;
                rise_d  = sync_out;
                fall_d  = ~sync_out;
            end else begin
                // Still proving stability; saturates at CNT_LAST by construction.
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Agreement falls through with cnt_d = 0 so any partial count is discarded.
    end

    // State and output flops; outputs come only from here, never from raw.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// ---------------------------------------------------------------------------
// Top: WIDTH independent lanes, no cross-pin interaction.
// ---------------------------------------------------------------------------
module gpio_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,     // 2..4
    parameter int DEBOUNCE_CYCLES = 1000   // 1..65535
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pin_raw_i,
    output logic [WIDTH-1:0] pin_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        gpio_debounce_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .raw   (pin_raw_i[g]),
            .level (pin_o[g]),
            .rise  (rise_o[g]),
            .fall  (fall_o[g])
        );
    end

endmodule
